// File: rtl/eth_transmitter.sv
// eth_transmitter: SPI-slave byte serializer for the Ethernet bridge.
// Reads a frame from the transmit buffer starting at address 0 and shifts
// it onto miso LSB-first, one bit per rising edge of sck, then raises done.
// Optional feature macro: ETH_TX_PAD_EN pads short frames with zero bytes
// up to PAD_LEN bytes before done is raised.
module eth_transmitter #(
    parameter int ADDR_W = 11
`ifdef ETH_TX_PAD_EN
    ,
    parameter int PAD_LEN = 60
`endif
) (
    input  logic              sck,
    input  logic              n_rst,
    input  logic              ena,
    input  logic [ADDR_W-1:0] tx_len,
    input  logic [7:0]        send_d,
    output logic [ADDR_W-1:0] send_a,
    output logic              n_send_buf_oe,
    output logic              miso,
    output logic              done
);

    // PAD is only ever entered when the padding feature is compiled in.
    typedef enum logic [1:0] {
        SEND = 2'd0,
        PAD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  bit_cnt;
    logic [6:0]  sr;
    logic        end_cond;
    logic        advance;
    logic        shifting;

    assign end_cond = (send_a == tx_len);

    // Next-state, bit-advance strobes and combinational outputs; reset forces idle outputs.
    always_comb begin
        next_state    = state;
        miso          = 1'b0;
        n_send_buf_oe = 1'b1;
        done          = 1'b0;
        advance       = 1'b0;
        shifting      = 1'b0;
        case (state)
            SEND: begin
                if (!end_cond) begin
                    if (ena) begin
                        n_send_buf_oe = 1'b0;
                        miso          = (bit_cnt == 3'd0) ? send_d[0] : sr[0];
                        advance       = 1'b1;
                        shifting      = 1'b1;
                    end
                end else begin
`ifdef ETH_TX_PAD_EN
                    if (send_a < ADDR_W'(PAD_LEN)) begin
                        advance = ena;
                        if (ena) begin
                            next_state = PAD;
                        end
                    end else begin
                        done       = 1'b1;
                        next_state = DONE;
                    end
`else
                    done       = 1'b1;
                    next_state = DONE;
`endif
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                if (send_a == ADDR_W'(PAD_LEN)) begin
                    done       = 1'b1;
                    next_state = DONE;
                end else begin
                    advance = ena;
                end
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                next_state = DONE;
            end
        endcase
        if (!n_rst) begin
            miso          = 1'b0;
            n_send_buf_oe = 1'b1;
            done          = 1'b0;
        end
    end

    // State register plus bit/byte counters and the 7-bit shift register.
    always_ff @(posedge sck or negedge n_rst) begin
        if (!n_rst) begin
            state   <= SEND;
            bit_cnt <= 3'd0;
            send_a  <= '0;
            sr      <= 7'd0;
        end else begin
            state <= next_state;
            if (advance) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    send_a <= send_a + ADDR_W'(1);
                end
            end
            if (shifting) begin
                sr <= (bit_cnt == 3'd0) ? send_d[7:1] : (sr >> 1);
            end
        end
    end

endmodule

// File: tb/tb_eth_transmitter.sv
// tb_eth_transmitter: scoreboard bench for eth_transmitter.
// The bench acts as SPI master (sck idles high, miso sampled on the falling
// edge) and as the asynchronous transmit buffer SRAM.
module tb_eth_transmitter;

    localparam int ADDR_W = 11;

    logic              sck;
    logic              n_rst;
    logic              ena;
    logic [ADDR_W-1:0] tx_len;
    logic [7:0]        send_d;
    logic [ADDR_W-1:0] send_a;
    logic              n_send_buf_oe;
    logic              miso;
    logic              done;

    logic [7:0] mem [0:2047];
    logic [7:0] exp_q [$];
    logic [7:0] rx_byte;
    int         rx_bit;
    int         checks;
    int         failures;

    eth_transmitter #(.ADDR_W(ADDR_W)) dut (
        .sck          (sck),
        .n_rst        (n_rst),
        .ena          (ena),
        .tx_len       (tx_len),
        .send_d       (send_d),
        .send_a       (send_a),
        .n_send_buf_oe(n_send_buf_oe),
        .miso         (miso),
        .done         (done)
    );

    assign send_d = mem[send_a];

    // Fill the buffer with the reference frame; bytes beyond it are junk.
    task automatic load_frame();
        logic [7:0] frame [7];
        frame = '{8'h10, 8'hd5, 8'h20, 8'hff, 8'h00, 8'ha5, 8'h73};
        for (int i = 0; i < 2048; i++) mem[i] = 8'hee;
        for (int i = 0; i < 7; i++) mem[i] = frame[i];
    endtask

    // Queue the reference frame as the expected master-side byte stream.
    task automatic push_frame();
        for (int i = 0; i < 7; i++) exp_q.push_back(mem[i]);
    endtask

    // One sck period: fall, sample miso, rise.
    task automatic pulse(output logic m);
        sck = 1'b0;
        #2;
        m = miso;
        #3;
        sck = 1'b1;
        #5;
    endtask

    // Assemble LSB-first bits into bytes and compare against the scoreboard.
    task automatic collect(input logic m);
        logic [7:0] exp;
        rx_byte[rx_bit] = m;
        rx_bit++;
        if (rx_bit == 8) begin
            rx_bit = 0;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL rx_byte: got %0h, no byte expected", rx_byte);
            end else begin
                exp = exp_q.pop_front();
                if (rx_byte !== exp) begin
                    failures++;
                    $display("[TB] FAIL rx_byte: got %0h expected %0h", rx_byte, exp);
                end
            end
        end
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] len);
        n_rst  = 1'b0;
        tx_len = len;
        rx_bit = 0;
        exp_q.delete();
        #3;
        n_rst = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        load_frame();
        mem[0] = 8'hff;
        ena    = 1'b1;
        tx_len = 11'd7;
        n_rst  = 1'b0;
        #3;
        checks++;
        if (miso !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_miso: got %b expected 0", miso);
        end
        checks++;
        if (n_send_buf_oe !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_oe: got %b expected 1", n_send_buf_oe);
        end
        checks++;
        if (send_a !== 11'd0) begin
            failures++; $display("[TB] FAIL reset_send_a: got %0d expected 0", send_a);
        end
        tx_len = 11'd0;
        #2;
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
    endtask

    task automatic test_frame();
        logic m;
        load_frame();
        ena = 1'b1;
        do_reset(11'd7);
        push_frame();
        for (int i = 0; i < 56; i++) begin
            if (i % 8 == 0) begin
                checks++;
                if (send_a !== 11'(i / 8)) begin
                    failures++; $display("[TB] FAIL frame_send_a: got %0d expected %0d", send_a, i / 8);
                end
            end
            if (i == 55) begin
                checks++;
                if (done !== 1'b0 || n_send_buf_oe !== 1'b0) begin
                    failures++; $display("[TB] FAIL frame_before_last: got done=%b oe=%b expected done=0 oe=0", done, n_send_buf_oe);
                end
            end
            pulse(m);
            collect(m);
        end
        checks++;
        if (done !== 1'b1 || n_send_buf_oe !== 1'b1 || send_a !== 11'd7 || miso !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_end: got done=%b oe=%b send_a=%0d miso=%b expected 1 1 7 0", done, n_send_buf_oe, send_a, miso);
        end
    endtask

    task automatic test_after_done();
        logic m;
        for (int i = 0; i < 16; i++) begin
            pulse(m);
            checks++;
            if (m !== 1'b0) begin
                failures++; $display("[TB] FAIL after_done_miso: got %b expected 0", m);
            end
        end
        checks++;
        if (send_a !== 11'd7 || done !== 1'b1) begin
            failures++; $display("[TB] FAIL after_done_state: got send_a=%0d done=%b expected 7 1", send_a, done);
        end
    endtask

    task automatic test_zero_len();
        logic m;
        load_frame();
        mem[0] = 8'hff;
        ena    = 1'b1;
        do_reset(11'd0);
        checks++;
        if (done !== 1'b1 || n_send_buf_oe !== 1'b1) begin
            failures++; $display("[TB] FAIL zero_len_idle: got done=%b oe=%b expected 1 1", done, n_send_buf_oe);
        end
        for (int i = 0; i < 8; i++) begin
            pulse(m);
            checks++;
            if (m !== 1'b0) begin
                failures++; $display("[TB] FAIL zero_len_miso: got %b expected 0", m);
            end
        end
        checks++;
        if (done !== 1'b1 || send_a !== 11'd0) begin
            failures++; $display("[TB] FAIL zero_len_end: got done=%b send_a=%0d expected 1 0", done, send_a);
        end
    endtask

    task automatic test_ena_pause();
        logic m;
        load_frame();
        ena = 1'b1;
        do_reset(11'd7);
        push_frame();
        for (int i = 0; i < 12; i++) begin
            pulse(m);
            collect(m);
        end
        ena = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse(m);
            checks++;
            if (m !== 1'b0 || n_send_buf_oe !== 1'b1) begin
                failures++; $display("[TB] FAIL pause_outputs: got miso=%b oe=%b expected 0 1", m, n_send_buf_oe);
            end
        end
        checks++;
        if (send_a !== 11'd1) begin
            failures++; $display("[TB] FAIL pause_send_a: got %0d expected 1", send_a);
        end
        ena = 1'b1;
        for (int i = 0; i < 44; i++) begin
            pulse(m);
            collect(m);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("[TB] FAIL pause_done: got %b expected 1", done);
        end
    endtask

    task automatic test_midframe_reset();
        logic m;
        load_frame();
        ena = 1'b1;
        do_reset(11'd7);
        push_frame();
        for (int i = 0; i < 20; i++) begin
            pulse(m);
            collect(m);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (send_a !== 11'd0 || miso !== 1'b0 || n_send_buf_oe !== 1'b1) begin
            failures++; $display("[TB] FAIL midreset_outputs: got send_a=%0d miso=%b oe=%b expected 0 0 1", send_a, miso, n_send_buf_oe);
        end
        exp_q.delete();
        rx_bit = 0;
        push_frame();
        #2;
        n_rst = 1'b1;
        #2;
        for (int i = 0; i < 56; i++) begin
            pulse(m);
            collect(m);
        end
        checks++;
        if (done !== 1'b1 || send_a !== 11'd7) begin
            failures++; $display("[TB] FAIL midreset_end: got done=%b send_a=%0d expected 1 7", done, send_a);
        end
    endtask

`ifdef ETH_TX_PAD_EN
    task automatic test_pad();
        logic m;
        for (int i = 0; i < 2048; i++) mem[i] = 8'hff;
        mem[0] = 8'haa;
        mem[1] = 8'h55;
        ena = 1'b1;
        do_reset(11'd2);
        exp_q.push_back(8'haa);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 58; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 480; i++) begin
            if (i == 479) begin
                checks++;
                if (done !== 1'b0) begin
                    failures++; $display("[TB] FAIL pad_early_done: got %b expected 0", done);
                end
            end
            pulse(m);
            collect(m);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("[TB] FAIL pad_done: got %b expected 1", done);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rx_bit   = 0;
        rx_byte  = 8'h00;
        sck      = 1'b1;
        n_rst    = 1'b0;
        ena      = 1'b0;
        tx_len   = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        #5;
        test_reset();
        test_frame();
        test_after_done();
        test_zero_len();
        test_ena_pause();
        test_midframe_reset();
`ifdef ETH_TX_PAD_EN
        test_pad();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("[TB] FAIL scoreboard_drain: got %0d bytes left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_transmitter.md
Name: eth_transmitter

Overview:
- SPI-slave byte serializer for the Ethernet bridge; it is the transmit-side counterpart of eth_receiver.
- Reads a frame out of the transmit buffer SRAM, starting at address 0, and shifts it onto miso LSB-first, clocked by the master's sck.
- Stops after tx_len bytes and raises done.
- Buffer port is asynchronous-read: address out, data in, active-low output enable.

Parameters:
- ADDR_W, 11, buffer address width and tx_len width.
- PAD_LEN, 60, minimum frame length in bytes. Used only with ETH_TX_PAD_EN.

Ports:
- sck  input  1  SPI clock; the sole clock. All state changes on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- ena  input  1  transmitter enable, sampled on the sck rising edge.
- tx_len  input  ADDR_W  frame length in bytes. Must be stable from n_rst deassertion until done.
- send_d  input  8  transmit buffer read data.
- send_a  output  ADDR_W  transmit buffer read address.
- n_send_buf_oe  output  1  buffer output enable, active low.
- miso  output  1  serial data out.
- done  output  1  high once the whole frame has been shifted out.

Behaviour:
- Clocking and reset:
  - One clock (sck); reset is asynchronous and active-low (n_rst).
  - While n_rst is low: send_a=0, bit_cnt=0, state=SEND, shift register=0, miso=0, n_send_buf_oe=1, done=0.
- State: 3-bit bit_cnt, ADDR_W-bit send_a counter, 7-bit shift register sr.
- FSM states:
  - SEND: frame bytes being shifted out.
  - PAD: only with ETH_TX_PAD_EN.
  - DONE: terminal state.
- end_cond = (send_a == tx_len).
- In SEND with !end_cond:
  - n_send_buf_oe = !ena.
  - miso = ena & (bit_cnt==0 ? send_d[0] : sr[0]).
  - Bit 0 comes directly from the buffer, so there is zero prefetch latency.
- Each rising sck edge with ena=1, in SEND with !end_cond:
  - bit_cnt==0: sr <= send_d[7:1].
  - bit_cnt 1..6: sr <= sr>>1.
  - bit_cnt wraps 7->0; on that wrap edge, send_a <= send_a+1.
- In SEND with end_cond true:
  - Outputs behave as DONE combinationally.
  - The next rising edge moves the FSM to DONE.
  - Consequence: tx_len=0 gives done=1 immediately after reset release, with no bits emitted.
- DONE:
  - miso=0, n_send_buf_oe=1, done=1.
  - Counters frozen; further sck edges are ignored.
  - Exit only via n_rst.
- ena=0:
  - miso=0, n_send_buf_oe=1.
  - All state is held; sck edges have no effect.
  - Position within the frame and within the byte is preserved.
  - Re-asserting ena resumes at the exact next bit.
  - done is not masked by ena.
- Peer timing: the master samples miso on the falling edge of sck. miso only changes after a rising edge (or after an asynchronous buffer/address change that follows a rising edge).
- Buffer timing: send_d must be valid before the first falling edge after send_a changes.
- Address never wraps. The maximum frame is 2^ADDR_W-1 bytes. Behaviour is undefined if tx_len changes mid-frame.
- Reset mid-frame: immediately returns to address 0, bit 0; partial byte discarded.

Optional Feature:
- Macro: ETH_TX_PAD_EN.
- Defined:
  - When end_cond is reached with send_a < PAD_LEN, the FSM enters PAD instead of DONE.
  - In PAD: miso=0, n_send_buf_oe=1, bit_cnt and send_a keep counting exactly as in SEND.
  - PAD goes to DONE when send_a == PAD_LEN.
  - done rises only after PAD_LEN*8 bits in total.
  - tx_len >= PAD_LEN behaves as the undefined build.
  - tx_len=0 pads 60 zero bytes.
- Undefined: no PAD state; SEND goes directly to DONE.

Test Plan:
1. Buffer = {10,d5,20,ff,00,a5,73}, tx_len=7, ena=1, 56 sck pulses -> master samples bytes 10,d5,20,ff,00,a5,73 LSB-first. send_a steps 0..7. done=1 after the 56th rising edge. n_send_buf_oe=1 afterwards.
2. Same frame plus 16 extra sck pulses after done -> miso stays 0, send_a stays 7, done stays 1.
3. tx_len=0, reset released -> done=1 and n_send_buf_oe=1 with no sck. 8 pulses give miso=0 throughout.
4. ena dropped after 12 bits (mid second byte), 8 pulses sent while disabled, ena raised again -> miso=0 while disabled. Resumed stream continues at bit 4 of byte d5. Reconstructed frame is identical to scenario 1.
5. n_rst pulsed low after 20 bits, then 56 pulses -> send_a=0 and miso=0 during reset. Full frame 10..73 retransmitted from the start.
6. ETH_TX_PAD_EN, tx_len=2, buffer {aa,55} -> bytes aa,55 followed by 58 bytes of 00. done rises after the 480th rising edge, not before.
